// File: rtl/multicycle_processor.sv
// multicycle_processor: two-cycle fetch/execute core with a writable instruction memory.
// Optional retired-instruction counter is built only when MPC_RETIRE_COUNT_EN is defined.
module multicycle_processor #(
  parameter int DATA_W      = 8,
  parameter int REGS        = 4,
  parameter int IMEM_DEPTH  = 16,
  localparam int RA_W       = $clog2(REGS),
  localparam int PC_W       = $clog2(IMEM_DEPTH),
  localparam int INSTR_W    = 3 + 3*RA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               imem_we,
  input  logic [PC_W-1:0]    imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  output logic               busy,
  output logic               halted,
  output logic [PC_W-1:0]    pc,
  output logic               wb_valid,
  output logic [RA_W-1:0]    wb_reg,
  output logic [DATA_W-1:0]  wb_data,
  output logic [15:0]        retired_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALTED} state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_LDI  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_BEQZ = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]    rf_q [REGS];
  logic [DATA_W-1:0]    rf_d [REGS];
  logic [INSTR_W-1:0]   mem_q [IMEM_DEPTH];
  logic                 wb_valid_q, wb_valid_d;
  logic [RA_W-1:0]      wb_reg_q, wb_reg_d;
  logic [DATA_W-1:0]    wb_data_q, wb_data_d;

  logic [2:0]           op;
  logic [RA_W-1:0]      rs1, rs2, rd;
  logic [2*RA_W-1:0]    imm;
  logic [PC_W-1:0]      target;
  logic                 is_write;
  logic                 ctl_open;

  assign op       = ir_q[INSTR_W-1 -: 3];
  assign rs1      = ir_q[3*RA_W-1 -: RA_W];
  assign rs2      = ir_q[2*RA_W-1 -: RA_W];
  assign rd       = ir_q[RA_W-1:0];
  assign imm      = ir_q[3*RA_W-1:RA_W];
  assign target   = ir_q[PC_W-1:0];
  assign is_write = (op == OP_ADD) || (op == OP_AND) || (op == OP_OR) ||
                    (op == OP_LDI) || (op == OP_SUB);
  // start and instruction writes are only accepted while the core is not running
  assign ctl_open = (state_q == S_IDLE) || (state_q == S_HALTED);

  function automatic logic [DATA_W-1:0] alu(input logic [2:0] f,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic [2*RA_W-1:0] k);
    case (f)
      OP_ADD:  alu = a + b;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_LDI:  alu = DATA_W'(k);
      OP_SUB:  alu = a - b;
      default: alu = '0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_EXEC;
      S_EXEC:   state_d = (op == OP_HALT) ? S_HALTED : S_FETCH;
      S_HALTED: if (start) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == S_FETCH) || (state_q == S_EXEC);
    halted = (state_q == S_HALTED);
  end

  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    rf_d       = rf_q;
    wb_valid_d = 1'b0;
    wb_reg_d   = wb_reg_q;
    wb_data_d  = wb_data_q;
    case (state_q)
      S_IDLE, S_HALTED: if (start) pc_d = '0;
      S_FETCH:          ir_d = mem_q[pc_q];
      S_EXEC: begin
        pc_d = pc_q + PC_W'(1);
        if (is_write) begin
          rf_d[rd]   = alu(op, rf_q[rs1], rf_q[rs2], imm);
          wb_valid_d = 1'b1;
          wb_reg_d   = rd;
          wb_data_d  = rf_d[rd];
        end
        case (op)
          OP_JMP:  pc_d = target;
          OP_BEQZ: if (rf_q[rs1] == '0) pc_d = target;
          OP_HALT: pc_d = pc_q;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      ir_q       <= '0;
      rf_q       <= '{default: '0};
      wb_valid_q <= 1'b0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      rf_q       <= rf_d;
      wb_valid_q <= wb_valid_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // instruction memory is deliberately left out of reset so programs survive rst
  always_ff @(posedge clk) begin
    if (imem_we && ctl_open) mem_q[imem_waddr] <= imem_wdata;
  end

  assign pc       = pc_q;
  assign wb_valid = wb_valid_q;
  assign wb_reg   = wb_reg_q;
  assign wb_data  = wb_data_q;

`ifdef MPC_RETIRE_COUNT_EN
  logic [15:0] ret_q, ret_d;
  always_comb ret_d = ret_q + ((state_q == S_EXEC) ? 16'd1 : 16'd0);
  always_ff @(posedge clk) begin
    if (rst) ret_q <= '0;
    else     ret_q <= ret_d;
  end
  assign retired_cnt = ret_q;
`else
  assign retired_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_multicycle_processor.sv
// Bench for multicycle_processor: instruction-level reference model driven by
// directed and random programs; each scenario task checks its own observations.
module tb_multicycle_processor;
  logic       clk = 1'b0;
  logic       rst, start, imem_we;
  logic [3:0] imem_waddr;
  logic [8:0] imem_wdata;
  logic       busy, halted, wb_valid;
  logic [3:0] pc;
  logic [1:0] wb_reg;
  logic [7:0] wb_data;
  logic [15:0] retired_cnt;

  multicycle_processor dut (
    .clk(clk), .rst(rst), .start(start), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .busy(busy), .halted(halted), .pc(pc), .wb_valid(wb_valid),
    .wb_reg(wb_reg), .wb_data(wb_data), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: architectural state stepped one instruction at a time
  logic [8:0] m_imem [16];
  logic [7:0] m_rf [4];
  logic [3:0] m_pc;
  logic [1:0] m_wreg;
  logic [7:0] m_wdata;
  int         m_ret;
  logic       e_wbv, e_halt;

  function automatic logic [15:0] exp_ret();
`ifdef MPC_RETIRE_COUNT_EN
    return 16'(m_ret % 65536);
`else
    return 16'h0;
`endif
  endfunction

  task automatic model_step();
    logic [8:0] w;
    logic [7:0] a, b;
    int r;
    logic wr;
    w = m_imem[m_pc];
    a = m_rf[w[5:4]];
    b = m_rf[w[3:2]];
    wr = 1'b1;
    r = 0;
    e_halt = 1'b0;
    m_ret++;
    case (w[8:6])
      3'd0: r = (int'(a) + int'(b)) % 256;
      3'd1: r = int'(a & b);
      3'd2: r = int'(a | b);
      3'd3: r = int'(w[5:2]);
      3'd4: r = (int'(a) - int'(b) + 256) % 256;
      default: wr = 1'b0;
    endcase
    e_wbv = wr;
    if (wr) begin
      m_rf[w[1:0]] = 8'(r);
      m_wreg  = w[1:0];
      m_wdata = 8'(r);
      m_pc = 4'((int'(m_pc) + 1) % 16);
    end else if (w[8:6] == 3'd5) m_pc = w[3:0];
    else if (w[8:6] == 3'd6) m_pc = (a == 8'd0) ? w[3:0] : 4'((int'(m_pc) + 1) % 16);
    else e_halt = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; imem_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_pc = 0; m_wreg = 0; m_wdata = 0; m_ret = 0;
    for (int i = 0; i < 4; i++) m_rf[i] = 8'd0;
  endtask

  task automatic load(input logic [3:0] addr, input logic [8:0] data);
    imem_we = 1'b1; imem_waddr = addr; imem_wdata = data;
    @(posedge clk); #1;
    imem_we = 1'b0;
    m_imem[addr] = data;
  endtask

  task automatic kick();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_pc = 0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic load_prog1();
    load(4'd0, 9'h0D5); load(4'd1, 9'h0CE); load(4'd2, 9'h01B); load(4'd3, 9'h1C0);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (pc !== 4'd0) begin n_fail++; $display("FAIL reset_pc got %0d exp 0", pc); end
    n_tests++; if ({busy, halted, wb_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl got %b exp 000", {busy, halted, wb_valid}); end
    n_tests++; if ({wb_reg, wb_data} !== 10'd0) begin n_fail++; $display("FAIL reset_wb got %0d/%h exp 0/00", wb_reg, wb_data); end
    n_tests++; if (retired_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_ret got %0d exp 0", retired_cnt); end
  endtask

  task automatic test_prog1(input string tag);
    logic [9:0] want [3];
    want[0] = {2'd1, 8'd5}; want[1] = {2'd2, 8'd3}; want[2] = {2'd3, 8'd8};
    kick();
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++; if (wb_valid !== e_wbv) begin n_fail++; $display("FAIL %s_wbv[%0d] got %0b exp %0b", tag, i, wb_valid, e_wbv); end
      n_tests++; if ({wb_reg, wb_data} !== {m_wreg, m_wdata}) begin n_fail++; $display("FAIL %s_wb[%0d] got %0d/%h exp %0d/%h", tag, i, wb_reg, wb_data, m_wreg, m_wdata); end
      if (i < 3) begin
        n_tests++; if ({wb_reg, wb_data} !== want[i]) begin n_fail++; $display("FAIL %s_const[%0d] got %0d/%h exp %h", tag, i, wb_reg, wb_data, want[i]); end
      end
      n_tests++; if (halted !== (i == 3)) begin n_fail++; $display("FAIL %s_halted[%0d] got %0b exp %0b", tag, i, halted, i == 3); end
    end
    n_tests++; if ({busy, pc} !== {1'b0, 4'd3}) begin n_fail++; $display("FAIL %s_end got busy=%0b pc=%0d exp busy=0 pc=3", tag, busy, pc); end
    n_tests++; if (retired_cnt !== exp_ret()) begin n_fail++; $display("FAIL %s_ret got %0d exp %0d", tag, retired_cnt, exp_ret()); end
  endtask

  task automatic test_sub();
    load(4'd0, 9'h0CD); load(4'd1, 9'h0D6); load(4'd2, 9'h11B); load(4'd3, 9'h1C0);
    kick();
    for (int i = 0; i < 3; i++) step();
    n_tests++; if ({wb_valid, wb_reg, wb_data} !== {1'b1, 2'd3, 8'hFE}) begin n_fail++; $display("FAIL sub got v=%0b %0d/%h exp 1 3/fe", wb_valid, wb_reg, wb_data); end
    n_tests++; if ({wb_reg, wb_data} !== {m_wreg, m_wdata}) begin n_fail++; $display("FAIL sub_model got %0d/%h exp %0d/%h", wb_reg, wb_data, m_wreg, m_wdata); end
    step();
  endtask

  task automatic test_beqz();
    do_reset();
    load(4'd0, 9'h185);
    kick(); step();
    n_tests++; if ({wb_valid, pc} !== {1'b0, 4'd5} || pc !== m_pc) begin n_fail++; $display("FAIL beqz_taken got v=%0b pc=%0d exp v=0 pc=5", wb_valid, pc); end
    do_reset();
    load(4'd0, 9'h0C4); load(4'd1, 9'h1C0);
    kick(); step(); step();
    load(4'd0, 9'h185);
    kick(); step();
    n_tests++; if ({wb_valid, pc} !== {1'b0, 4'd1} || pc !== m_pc) begin n_fail++; $display("FAIL beqz_not got v=%0b pc=%0d exp v=0 pc=1", wb_valid, pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int a = 0; a < 16; a++) load(4'(a), {3'b011, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))});
    kick();
    for (int i = 0; i < 20; i++) begin
      step();
      n_tests++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_wbv[%0d] got %0b exp 1", i, wb_valid); end
      n_tests++; if ({wb_reg, wb_data, pc} !== {m_wreg, m_wdata, m_pc}) begin n_fail++; $display("FAIL wrap[%0d] got %0d/%h pc=%0d exp %0d/%h pc=%0d", i, wb_reg, wb_data, pc, m_wreg, m_wdata, m_pc); end
      if (i == 15) begin
        n_tests++; if (pc !== 4'd0) begin n_fail++; $display("FAIL wrap_pc0 got %0d exp 0", pc); end
      end
    end
  endtask

  task automatic test_rst_mid_exec();
    do_reset();
    load_prog1();
    kick(); step(); step();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_pc = 0; m_wreg = 0; m_wdata = 0; m_ret = 0;
    for (int i = 0; i < 4; i++) m_rf[i] = 8'd0;
    n_tests++; if ({wb_valid, busy, halted, pc} !== 7'd0) begin n_fail++; $display("FAIL rstmid_ctl got v=%0b busy=%0b h=%0b pc=%0d exp all 0", wb_valid, busy, halted, pc); end
    n_tests++; if ({wb_reg, wb_data, retired_cnt} !== 26'd0) begin n_fail++; $display("FAIL rstmid_wb got %0d/%h ret=%0d exp 0", wb_reg, wb_data, retired_cnt); end
    test_prog1("rstmid");
  endtask

  task automatic test_busy_ignore();
    do_reset();
    load_prog1();
    kick();
    imem_we = 1'b1; imem_waddr = 4'd0; imem_wdata = 9'h1C0; start = 1'b1;
    step();
    imem_we = 1'b0; start = 1'b0;
    n_tests++; if ({wb_valid, wb_reg, wb_data, pc} !== {1'b1, 2'd1, 8'd5, 4'd1}) begin n_fail++; $display("FAIL busy_first got %0d/%h pc=%0d exp 1/05 pc=1", wb_reg, wb_data, pc); end
    for (int i = 0; i < 3; i++) step();
    n_tests++; if ({halted, wb_reg, wb_data} !== {1'b1, 2'd3, 8'd8}) begin n_fail++; $display("FAIL busy_run got h=%0b %0d/%h exp 1 3/08", halted, wb_reg, wb_data); end
    kick(); step();
    n_tests++; if ({wb_valid, wb_reg, wb_data} !== {1'b1, 2'd1, 8'd5}) begin n_fail++; $display("FAIL busy_rerun got %0d/%h exp 1/05", wb_reg, wb_data); end
  endtask

  task automatic test_we_with_start();
    logic [8:0] w;
    do_reset();
    w = {3'b011, 4'($urandom_range(1, 15)), 2'd3};
    imem_we = 1'b1; imem_waddr = 4'd0; imem_wdata = w; start = 1'b1;
    @(posedge clk); #1;
    imem_we = 1'b0; start = 1'b0;
    m_imem[0] = w; m_pc = 0;
    step();
    n_tests++; if ({wb_valid, wb_reg, wb_data} !== {1'b1, 2'd3, 4'd0, w[5:2]}) begin n_fail++; $display("FAIL we_start got %0d/%h exp 3/%h", wb_reg, wb_data, w[5:2]); end
  endtask

  task automatic test_random();
    for (int p = 0; p < 5; p++) begin
      do_reset();
      for (int a = 0; a < 16; a++) load(4'(a), 9'($urandom_range(0, 511)));
      kick();
      for (int i = 0; i < 30; i++) begin
        step();
        n_tests++; if ({wb_valid, halted} !== {e_wbv, e_halt}) begin n_fail++; $display("FAIL rand[%0d.%0d] got v=%0b h=%0b exp v=%0b h=%0b", p, i, wb_valid, halted, e_wbv, e_halt); end
        n_tests++; if ({wb_reg, wb_data, pc} !== {m_wreg, m_wdata, m_pc}) begin n_fail++; $display("FAIL rand_st[%0d.%0d] got %0d/%h pc=%0d exp %0d/%h pc=%0d", p, i, wb_reg, wb_data, pc, m_wreg, m_wdata, m_pc); end
        if (e_halt) break;
      end
      n_tests++; if (retired_cnt !== exp_ret()) begin n_fail++; $display("FAIL rand_ret[%0d] got %0d exp %0d", p, retired_cnt, exp_ret()); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    test_reset();
    load_prog1();
    test_prog1("prog1");
    test_sub();
    test_beqz();
    test_wrap();
    test_rst_mid_exec();
    test_busy_ignore();
    test_we_with_start();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
